// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store funct3 codes and the opcodes the core decodes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and fault
// detection on the request side; lane select and sign/zero extension on return.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] data_out,
  output logic        fault,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic        illegal;
  logic        misaligned;
  logic [31:0] shifted;

  always_comb begin
    illegal     = store ? (funct3 > SW)
                        : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misaligned  = 1'b0;
    byte_enable = 4'b1111;
    data_out    = wdata;
    case (funct3[1:0])
      2'b00: begin
        byte_enable = 4'b0001 << addr_lo;
        data_out    = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned  = addr_lo[0];
        byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
        data_out    = {2{wdata[15:0]}};
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
    fault = illegal || misaligned;
  end

  always_comb begin
    shifted = rdata >> {rsp_addr_lo, 3'b000};
    case (rsp_funct3)
      LB:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LH:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LW:      rdata_ext = rdata;
      LBU:     rdata_ext = {24'h0, shifted[7:0]};
      LHU:     rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one request per transaction, registered bus
// strobes held until ack or timeout, single-cycle tagged response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_STORE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [4:0]  REQ_RD,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic [4:0]  RESP_RD,
  output logic        RESP_ERR,
  output logic [31:0] DATA_ADDR,
  output logic [31:0] DATA_OUT,
  input  logic [31:0] DATA_IN,
  output logic [3:0]  BYTE_ENABLE,
  output logic        WRITE_ENABLE,
  output logic        READ_ENABLE,
  input  logic        DATA_ACK
);

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic [31:0] wait_count;

  logic [3:0]  be_next;
  logic [31:0] dout_next;
  logic        fault;
  logic [31:0] rdata_ext;

  lsu_align u_align (
    .store       (REQ_STORE),
    .funct3      (REQ_FUNCT3),
    .addr_lo     (REQ_ADDR[1:0]),
    .wdata       (REQ_WDATA),
    .byte_enable (be_next),
    .data_out    (dout_next),
    .fault       (fault),
    .rsp_funct3  (funct3_q),
    .rsp_addr_lo (addr_lo_q),
    .rdata       (DATA_IN),
    .rdata_ext   (rdata_ext)
  );

  assign REQ_READY = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      wait_count   <= '0;
      RESP_VALID   <= 1'b0;
      RESP_ERR     <= 1'b0;
      RESP_RDATA   <= '0;
      RESP_RD      <= '0;
      DATA_ADDR    <= '0;
      DATA_OUT     <= '0;
      BYTE_ENABLE  <= '0;
      READ_ENABLE  <= 1'b0;
      WRITE_ENABLE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            store_q    <= REQ_STORE;
            funct3_q   <= REQ_FUNCT3;
            addr_lo_q  <= REQ_ADDR[1:0];
            rd_q       <= REQ_RD;
            wait_count <= '0;
            if (fault) begin
              state      <= RESP;
              RESP_VALID <= 1'b1;
              RESP_ERR   <= 1'b1;
              RESP_RDATA <= '0;
              RESP_RD    <= '0;
            end else begin
              state        <= BUS;
              DATA_ADDR    <= {REQ_ADDR[31:2], 2'b00};
              BYTE_ENABLE  <= be_next;
              DATA_OUT     <= dout_next;
              READ_ENABLE  <= !REQ_STORE;
              WRITE_ENABLE <= REQ_STORE;
            end
          end
        end
        BUS: begin
          // Ack is tested first so it wins over a timeout landing in the same cycle.
          if (DATA_ACK) begin
            state        <= RESP;
            READ_ENABLE  <= 1'b0;
            WRITE_ENABLE <= 1'b0;
            RESP_VALID   <= 1'b1;
            RESP_ERR     <= 1'b0;
            RESP_RDATA   <= store_q ? '0 : rdata_ext;
            RESP_RD      <= store_q ? '0 : rd_q;
          end else begin
            wait_count <= wait_count + 32'd1;
            if (TIMEOUT_CYCLES != 0 && wait_count + 32'd1 == TIMEOUT_CYCLES) begin
              state        <= RESP;
              READ_ENABLE  <= 1'b0;
              WRITE_ENABLE <= 1'b0;
              RESP_VALID   <= 1'b1;
              RESP_ERR     <= 1'b1;
              RESP_RDATA   <= '0;
              RESP_RD      <= '0;
            end
          end
        end
        RESP: begin
          state      <= IDLE;
          RESP_VALID <= 1'b0;
          RESP_ERR   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver that also plays the memory,
// and a monitor that pops expected responses whenever RESP_VALID is seen.
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_STORE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = '0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic [4:0]  REQ_RD = '0;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic [4:0]  RESP_RD;
  logic        RESP_ERR;
  logic [31:0] DATA_ADDR;
  logic [31:0] DATA_OUT;
  logic [31:0] DATA_IN = '0;
  logic [3:0]  BYTE_ENABLE;
  logic        WRITE_ENABLE;
  logic        READ_ENABLE;
  logic        DATA_ACK = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_STORE(REQ_STORE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_RD(REQ_RD),
    .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_RD(RESP_RD), .RESP_ERR(RESP_ERR),
    .DATA_ADDR(DATA_ADDR), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN),
    .BYTE_ENABLE(BYTE_ENABLE), .WRITE_ENABLE(WRITE_ENABLE), .READ_ENABLE(READ_ENABLE),
    .DATA_ACK(DATA_ACK)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, lanes from the aligned base.
  function automatic logic model_fault(logic st, logic [2:0] f3, logic [31:0] a);
    int unsigned sz;
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic int unsigned base_of(logic [2:0] f3, logic [31:0] a);
    int unsigned sz;
    sz = 1 << f3[1:0];
    return (a % 4) - ((a % 4) % sz);
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
    int unsigned sz, b;
    logic [3:0] be;
    sz = 1 << f3[1:0];
    b = base_of(f3, a);
    be = '0;
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_dout(logic [2:0] f3, logic [31:0] wd);
    int unsigned sz;
    logic [31:0] r;
    sz = 1 << f3[1:0];
    r = '0;
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] mem);
    int unsigned sz;
    logic [31:0] v, mask;
    sz = 1 << f3[1:0];
    v = mem >> (8 * base_of(f3, a));
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && RESP_VALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got RESP_VALID=1 expected no response (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", RESP_RDATA, mon_e.rdata);
        check("resp_rd", RESP_RD, mon_e.rd);
        check("resp_err", RESP_ERR, mon_e.err);
        check("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input int unsigned waits, input logic [31:0] mem);
    exp_t        e;
    logic        flt, acked;
    int unsigned k_end, a_cyc;
    flt   = model_fault(st, f3, a);
    acked = (waits + 1 <= TMO);
    k_end = acked ? waits + 1 : TMO;
    @(negedge clk);
    DATA_ACK = 1'b0;
    check("req_ready_idle", REQ_READY, 1);
    REQ_VALID  = 1'b1;
    REQ_STORE  = st;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = a;
    REQ_WDATA  = wd;
    REQ_RD     = rd;
    @(posedge clk);
    #1;
    a_cyc     = cyc;
    REQ_VALID = 1'b0;
    REQ_ADDR  = $urandom;
    REQ_WDATA = $urandom;
    REQ_RD    = 5'($urandom);
    if (flt) begin
      e.rdata = '0;
      e.rd    = '0;
      e.err   = 1'b1;
      e.cyc   = a_cyc;
      exp_q.push_back(e);
    end else begin
      e.err   = !acked;
      e.rd    = (acked && !st) ? rd : 5'd0;
      e.rdata = (acked && !st) ? model_load(f3, a, mem) : 32'd0;
      e.cyc   = a_cyc + k_end;
      exp_q.push_back(e);
      for (int unsigned k = 1; k <= k_end; k++) begin
        @(negedge clk);
        check("read_enable", READ_ENABLE, !st);
        check("write_enable", WRITE_ENABLE, st);
        check("data_addr", DATA_ADDR, a & ~32'h3);
        check("byte_enable", BYTE_ENABLE, model_be(f3, a));
        if (st) check("data_out", DATA_OUT, model_dout(f3, wd));
        check("req_ready_bus", REQ_READY, 0);
        if (acked && k == k_end) begin
          DATA_ACK = 1'b1;
          DATA_IN  = mem;
        end else begin
          DATA_IN  = $urandom;
        end
      end
    end
    @(negedge clk);
    check("strobes_resp", {READ_ENABLE, WRITE_ENABLE}, 0);
    check("req_ready_resp", REQ_READY, 0);
    // A stray ack while responding after an error must be ignored.
    DATA_ACK = flt ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", REQ_READY, 1);
    check("rst_resp_valid", RESP_VALID, 0);
    check("rst_resp_err", RESP_ERR, 0);
    check("rst_strobes", {READ_ENABLE, WRITE_ENABLE}, 0);
    check("rst_byte_enable", BYTE_ENABLE, 0);
    check("rst_data_addr", DATA_ADDR, 0);
    check("rst_data_out", DATA_OUT, 0);
    check("rst_resp_rdata", RESP_RDATA, 0);
    check("rst_resp_rd", RESP_RD, 0);
    rst_n = 1'b1;

    do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h80AA_5511);
    do_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd9, 3, 32'hBEEF_1234);
    do_access(1'b1, 3'b001, 32'h0000_0010, 32'h0000_CAFE, 5'd3, 2, 32'h1234_5678);
    do_access(1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd4, 0, 32'h0);
    do_access(1'b1, 3'b011, 32'h0000_0040, 32'h1111_2222, 5'd5, 0, 32'h0);
    do_access(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd6, 6, 32'hDEAD_BEEF);
    do_access(1'b0, 3'b010, 32'h0000_0024, 32'h0, 5'd8, 3, 32'hCAFE_F00D);

    // Reset in the middle of a waited load: no response may follow.
    @(negedge clk);
    REQ_VALID  = 1'b1;
    REQ_STORE  = 1'b0;
    REQ_FUNCT3 = 3'b010;
    REQ_ADDR   = 32'h0000_0400;
    REQ_RD     = 5'd10;
    @(posedge clk);
    #1;
    REQ_VALID = 1'b0;
    @(negedge clk);
    check("re_before_reset", READ_ENABLE, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_strobes", {READ_ENABLE, WRITE_ENABLE}, 0);
    check("reset_req_ready", REQ_READY, 1);
    check("reset_resp_valid", RESP_VALID, 0);
    rst_n = 1'b1;
    do_access(1'b0, 3'b100, 32'h0000_0401, 32'h0, 5'd11, 1, 32'h0000_9A00);

    for (int n = 0; n < 200; n++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                5'($urandom), $urandom_range(0, 5), $urandom);
    end

    DATA_ACK = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_responses", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the RV32I core and the data memory bus. Accepts one LOAD/STORE request per transaction from the core's execute stage, with the effective address already computed. Drives the data bus with a word-aligned address, byte enables and replicated store data, and waits for the memory acknowledge. Returns a sign- or zero-extended load result, or a completion/error response, tagged with the destination register.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of BUS-state cycles without DATA_ACK before the access is aborted with an error; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  the core presents a request.
- REQ_READY  out  1  the unit is idle and accepts a request.
- REQ_STORE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  width/sign code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- REQ_ADDR  in  32  effective byte address.
- REQ_WDATA  in  32  store data (rs2).
- REQ_RD  in  5  destination register tag.
- RESP_VALID  out  1  one-cycle response pulse.
- RESP_RDATA  out  32  extended load data; 0 for stores and errors.
- RESP_RD  out  5  tag; forced to 0 for stores and errors.
- RESP_ERR  out  1  misaligned access, illegal funct3, or timeout.
- DATA_ADDR  out  32  {addr[31:2], 2'b00}.
- DATA_OUT  out  32  replicated store data.
- DATA_IN  in  32  read data, valid in the DATA_ACK cycle.
- BYTE_ENABLE  out  4  active byte lanes.
- WRITE_ENABLE  out  1  store strobe, held high until ack.
- READ_ENABLE  out  1  load strobe, held high until ack.
- DATA_ACK  in  1  memory completion.

## Operation
- States: IDLE, BUS, RESP. REQ_READY = (state == IDLE).
- IDLE:
  - On REQ_VALID && REQ_READY && rst_n, latch all request fields.
  - Illegal funct3 or misaligned address -> RESP with error, no bus cycle.
  - Otherwise -> BUS.
- Misalignment: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
- Illegal funct3: loads 011/110/111; stores ≥ 011.
- Byte lanes:
  - Byte access: BE = 1 << addr[1:0]; DATA_OUT = {4{wdata[7:0]}}.
  - Halfword access: BE = addr[1] ? 1100 : 0011; DATA_OUT = {2{wdata[15:0]}}.
  - Word access: BE = 1111; DATA_OUT = wdata.
- BUS:
  - Strobe (READ_ENABLE or WRITE_ENABLE), DATA_ADDR, BYTE_ENABLE and DATA_OUT are registered and stable for the whole state.
  - On DATA_ACK, capture DATA_IN, select the addressed lane, extend per funct3 -> RESP.
  - The timeout counter increments on every BUS cycle without ack. When it reaches TIMEOUT_CYCLES -> RESP with RESP_ERR = 1.
  - If DATA_ACK arrives in the timeout cycle, the ack wins.
- RESP: RESP_VALID = 1 for exactly one cycle; strobes are low. Next state is always IDLE. There is no backpressure: the core must consume the response.
- DATA_ACK outside BUS is ignored.

## Timing
- Reset values:
  - REQ_READY = 1.
  - RESP_VALID, RESP_ERR, READ_ENABLE, WRITE_ENABLE = 0.
  - BYTE_ENABLE = 0000.
  - DATA_ADDR, DATA_OUT, RESP_RDATA = 0; RESP_RD = 0.
  - Timeout counter = 0.
- Request accepted at edge N:
  - Strobes high from N+1.
  - Zero-wait ack at N+1 gives RESP_VALID during N+2 and REQ_READY high during N+3.
  - Minimum accept-to-response latency is 2 cycles. Throughput is one access per 3 cycles at best.
- Error detected at accept: RESP_VALID during N+1, with no strobe asserted.
- Strobes fall in the cycle after DATA_ACK is sampled.
- rst_n low while in BUS or RESP: at the next edge, strobes drop, the state returns to IDLE, and no response is issued.

## Structure
- Package lsu_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the LOAD/STORE opcode constants shared with the core.
- One combinational sub-module, lsu_align. It has two functions:
  - request side: address/funct3 in, BYTE_ENABLE, replicated DATA_OUT and misalign/illegal flag out;
  - response side: DATA_IN, addr[1:0] and funct3 in, extended result out.
- FSM, timeout counter and output registers live in load_store_unit.

## Test plan
- LB at 0x103, zero-wait ack, DATA_IN = 0x80AA5511 -> BE = 1000, DATA_ADDR = 0x100, RESP_RDATA = 0xFFFFFF80, RESP_RD = tag, response 2 cycles after accept.
- LHU at 0x202, ack after 3 wait cycles, DATA_IN = 0xBEEF1234 -> BE = 1100, READ_ENABLE high for 4 cycles, RESP_RDATA = 0x0000BEEF.
- SH 0x0000CAFE at 0x10 -> BE = 0011, DATA_OUT = 0xCAFECAFE, WRITE_ENABLE until ack, RESP_RD = 0, RESP_ERR = 0.
- LW at 0x6 -> no strobe, RESP_VALID with RESP_ERR = 1 one cycle after accept. Store with funct3 = 011 -> same error response.
- TIMEOUT_CYCLES = 4, no ack -> RESP_ERR after 4 BUS cycles. Repeat with ack in the 4th cycle -> normal response.
- rst_n low during a waited load -> strobes 0 at the next edge, no RESP_VALID, REQ_READY = 1. A new request then completes normally.
